// File: rtl/cache_region_ctr.sv
// cache_region_ctr: control/configuration slave for the data/instruction cache.
//
// Holds CTRL, STATUS and REGION_NUM programmable uncached address windows.
// Classifies the cache lookup address as IO/uncached. Queues and coalesces
// write-back and clear requests, and hands them to the cache core over a
// valid/ready handshake. A write-back is always issued before a clear.
//
// Ports:
//   clk, rest            clock, asynchronous active-high reset
//   s0_*                 register slave (word index = s0_address[31:2])
//   address              cache lookup address
//   isIOAddrBlock        lookup address is uncached
//   isEnableCache        cache enable (CTRL[16])
//   cmd/cmd_valid        command to cache core; cmd_ready accepts it
//   hit_pulse/miss_pulse cache hit/miss events (performance counters only)
//
// Word map: 0 CTRL, 1 STATUS, 2+2i / 3+2i region i low / high bound,
//           2+2*REGION_NUM HIT, 3+2*REGION_NUM MISS. Other indices read 0.
//
// Optional feature macro: CACHE_CTR_PERF_EN enables the saturating 32-bit
// HIT/MISS counters. Without it both indices read 0 and the pulses are ignored.

`ifndef CACHE_CTR_CMD_WB
`define CACHE_CTR_CMD_WB 3'd1
`endif
`ifndef CACHE_CTR_CMD_CLEAR
`define CACHE_CTR_CMD_CLEAR 3'd2
`endif

module cache_region_ctr #(
    parameter int REGION_NUM = 4,
    parameter int GRAN_BITS  = 10,
    parameter int CNT_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] s0_address,
    input  logic [3:0]  s0_byteEnable,
    input  logic        s0_read,
    output logic [31:0] s0_readData,
    input  logic        s0_write,
    input  logic [31:0] s0_writeData,
    output logic        s0_waitRequest,
    output logic        s0_readDataValid,
    input  logic [31:0] address,
    output logic        isIOAddrBlock,
    output logic        isEnableCache,
    output logic [2:0]  cmd,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic        hit_pulse,
    input  logic        miss_pulse
);

    localparam int BW = 32 - GRAN_BITS;

    // state    | meaning
    // ST_IDLE  | no command on the bus; picks the next pending request
    // ST_ISSUE | cmd/cmd_valid held until cmd_ready
    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

    logic [29:0] word_idx;
    assign word_idx = s0_address[31:2];

    logic [REGION_NUM-1:0] reg_en_q, reg_en_d;
    logic                  cache_en_q, cache_en_d;
    logic [BW-1:0]         lo_q [REGION_NUM];
    logic [BW-1:0]         lo_d [REGION_NUM];
    logic [BW-1:0]         hi_q [REGION_NUM];
    logic [BW-1:0]         hi_d [REGION_NUM];
    logic                  pend_wb_q, pend_wb_d;
    logic                  pend_clr_q, pend_clr_d;
    logic [2:0]            cmd_q, cmd_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    state_t                state_q, state_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    logic        set_wb, set_clr, done_wb, done_clr, busy;
    logic [31:0] rd_mux;

    logic unused_ok;
    assign unused_ok = ^{s0_byteEnable, s0_address, address, s0_writeData};

    // Register writes and request capture
    always_comb begin
        reg_en_d   = reg_en_q;
        cache_en_d = cache_en_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        set_wb     = 1'b0;
        set_clr    = 1'b0;
        if (s0_write) begin
            if (word_idx == 30'd0) begin
                reg_en_d   = s0_writeData[REGION_NUM-1:0];
                cache_en_d = s0_writeData[16];
                set_wb     = s0_writeData[17];
                // Disabling the cache implies its contents must be cleared.
                set_clr    = s0_writeData[18] | (cache_en_q & ~s0_writeData[16]);
            end
            for (int i = 0; i < REGION_NUM; i++) begin
                if (word_idx == 30'(2 + 2 * i)) lo_d[i] = s0_writeData[31:GRAN_BITS];
                if (word_idx == 30'(3 + 2 * i)) hi_d[i] = s0_writeData[31:GRAN_BITS];
            end
        end
    end

    // Command sequencer
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        cnt_d       = cnt_q;
        done_wb     = 1'b0;
        done_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_wb_q) begin
                    cmd_d       = `CACHE_CTR_CMD_WB;
                    cmd_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else if (pend_clr_q) begin
                    cmd_d       = `CACHE_CTR_CMD_CLEAR;
                    cmd_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    cnt_d       = cnt_q + CNT_WIDTH'(1);
                    if (cmd_q == `CACHE_CTR_CMD_WB) done_wb = 1'b1;
                    else                            done_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new request arriving with the completion keeps the flag set.
        pend_wb_d  = (pend_wb_q  & ~done_wb)  | set_wb;
        pend_clr_d = (pend_clr_q & ~done_clr) | set_clr;
    end

    assign busy = cmd_valid_q | pend_wb_q | pend_clr_q;

`ifdef CACHE_CTR_PERF_EN
    localparam int HIT_IDX  = 2 + 2 * REGION_NUM;
    localparam int MISS_IDX = 3 + 2 * REGION_NUM;

    logic [31:0] hit_q, hit_d, miss_q, miss_d;
    logic        perf_clr;

    always_comb begin
        perf_clr = s0_write && ((word_idx == 30'(HIT_IDX)) || (word_idx == 30'(MISS_IDX)));
        hit_d    = hit_q;
        miss_d   = miss_q;
        if (perf_clr) begin
            hit_d  = '0;
            miss_d = '0;
        end else begin
            if (hit_pulse  && (hit_q  != 32'hFFFF_FFFF)) hit_d  = hit_q  + 32'd1;
            if (miss_pulse && (miss_q != 32'hFFFF_FFFF)) miss_d = miss_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = hit_pulse ^ miss_pulse;
`endif

    // Read mux on current register values (same-cycle write is not visible)
    always_comb begin
        rd_mux = '0;
        if (word_idx == 30'd0) begin
            rd_mux[REGION_NUM-1:0] = reg_en_q;
            rd_mux[16]             = cache_en_q;
        end else if (word_idx == 30'd1) begin
            rd_mux[0]              = busy;
            rd_mux[1]              = pend_wb_q;
            rd_mux[2]              = pend_clr_q;
            rd_mux[8 +: CNT_WIDTH] = cnt_q;
        end
        for (int i = 0; i < REGION_NUM; i++) begin
            if (word_idx == 30'(2 + 2 * i)) rd_mux = {lo_q[i], {GRAN_BITS{1'b0}}};
            if (word_idx == 30'(3 + 2 * i)) rd_mux = {hi_q[i], {GRAN_BITS{1'b0}}};
        end
`ifdef CACHE_CTR_PERF_EN
        if (word_idx == 30'(HIT_IDX))  rd_mux = hit_q;
        if (word_idx == 30'(MISS_IDX)) rd_mux = miss_q;
`endif
        rdata_d  = s0_read ? rd_mux : rdata_q;
        rvalid_d = s0_read;
    end

    // Uncached classification; lo > hi never matches, so it is an empty window.
    always_comb begin
        isIOAddrBlock = address[31];
        for (int i = 0; i < REGION_NUM; i++) begin
            if (reg_en_q[i] && (lo_q[i] <= address[31:GRAN_BITS]) &&
                (address[31:GRAN_BITS] <= hi_q[i]))
                isIOAddrBlock = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            reg_en_q    <= '0;
            cache_en_q  <= 1'b1;
            for (int i = 0; i < REGION_NUM; i++) begin
                lo_q[i] <= '0;
                hi_q[i] <= '0;
            end
            pend_wb_q   <= 1'b0;
            pend_clr_q  <= 1'b0;
            cmd_q       <= `CACHE_CTR_CMD_WB;
            cmd_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            reg_en_q    <= reg_en_d;
            cache_en_q  <= cache_en_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            pend_wb_q   <= pend_wb_d;
            pend_clr_q  <= pend_clr_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign s0_readData      = rdata_q;
    assign s0_readDataValid = rvalid_q;
    assign s0_waitRequest   = 1'b0;
    assign isEnableCache    = cache_en_q;
    assign cmd              = cmd_q;
    assign cmd_valid        = cmd_valid_q;

endmodule
